// File: rtl/serial_addsub_n.sv
// serial_addsub_n: bit-serial adder/subtractor.
// Two WIDTH-bit operands arrive LSB-first, one bit pair per accepted cycle.
// Each result bit is echoed on s/s_valid. The full word, carry-out and
// signed overflow are presented in parallel with a one-cycle done pulse.
//
// Handshake: a bit pair on a/b is consumed on a rising edge only when the
// FSM is in RUN and bit_valid=1. There is no back-pressure; the source
// stalls by holding bit_valid low. start is taken only in IDLE. s_valid is
// high for exactly one cycle per consumed pair. sum/cout/ovf are stable
// from the done cycle until the next word completes.
module serial_addsub_n #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic             bit_valid,
  input  logic             a,
  input  logic             b,
  output logic             s,
  output logic             s_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               mode_q;
  logic [WIDTH-1:0]   sh;

  logic               b_eff;
  logic               bit_sum;
  logic               carry_nxt;
  logic               last_bit;

  // Full-adder slice; subtraction inverts B and relies on carry preset to 1.
  always_comb begin
    b_eff     = b ^ mode_q;
    bit_sum   = a ^ b_eff ^ carry;
    carry_nxt = (a & b_eff) | (a & carry) | (b_eff & carry);
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (bit_valid && last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    busy      = (state == RUN) || (state == DONE);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Datapath: operand latch, serial bit processing and result capture.
  // While the last bit is processed, carry still holds the carry into the
  // MSB, so overflow is that value XOR the carry out of the MSB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      carry   <= 1'b0;
      mode_q  <= 1'b0;
      sh      <= '0;
      s       <= 1'b0;
      s_valid <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            carry  <= mode ? 1'b1 : cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (bit_valid) begin
            carry   <= carry_nxt;
            sh      <= {bit_sum, sh[WIDTH-1:1]};
            s       <= bit_sum;
            s_valid <= 1'b1;
            cnt     <= cnt + CNT_W'(1);
            if (last_bit) begin
              sum  <= {bit_sum, sh[WIDTH-1:1]};
              cout <= carry_nxt;
              ovf  <= carry ^ carry_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_n.sv
// tb_serial_addsub_n: directed test of serial_addsub_n (WIDTH=8).
module tb_serial_addsub_n;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         mode;
  logic         cin;
  logic         bit_valid;
  logic         a;
  logic         b;
  logic         s;
  logic         s_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  serial_addsub_n #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .cin       (cin),
    .bit_valid (bit_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .s_valid   (s_valid),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one word. Inputs change on negedges; outputs are sampled on
  // negedges. lat counts rising edges from the start edge to the edge that
  // first samples done high.
  task automatic run_case(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic m, input logic ci, input int stall_at, input int stall_len,
                          input logic poke, input logic exp_cout, input logic exp_ovf,
                          input int exp_lat);
    int i, gap, e, nval, lat;
    logic seen;
    logic [W-1:0] sbits;
    logic [W-1:0] exp_sum;
    logic [W-1:0] sum_d;
    logic cout_d, ovf_d;
    exp_sum = exp_q.pop_front();
    @(negedge clk);
    start = 1'b1; mode = m; cin = ci; bit_valid = 1'b0;
    @(negedge clk);
    start = poke;
    mode = $urandom_range(0, 1); cin = $urandom_range(0, 1);
    i = 0; gap = 0; e = 0; nval = 0; lat = -1; seen = 1'b0;
    sbits = '0; sum_d = '0; cout_d = 1'b0; ovf_d = 1'b0;
    while (!seen && e < 40) begin
      if (i < W && !(i == stall_at && gap < stall_len)) begin
        bit_valid = 1'b1; a = av[i]; b = bv[i]; i++;
      end else begin
        bit_valid = 1'b0; a = $urandom_range(0, 1); b = $urandom_range(0, 1);
        if (i == stall_at && gap < stall_len) gap++;
      end
      @(negedge clk);
      e++;
      if (s_valid) begin
        if (nval < W) sbits[nval] = s;
        nval++;
      end
      if (done) begin
        seen = 1'b1; lat = e + 1;
        sum_d = sum; cout_d = cout; ovf_d = ovf;
      end
    end
    bit_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_sum"}, 32'(sum_d), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout_d), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(ovf_d), 32'(exp_ovf));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_s_count"}, 32'(nval), 32'(W));
    check({tag, "_s_stream"}, 32'(sbits), 32'(exp_sum));
    // start (if poked) is still high across the DONE edge.
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_state"}, 32'(state_dbg), 32'd0);
    @(negedge clk);
    check({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    bit [W-1:0] zero_w;
    logic any_done;
    zero_w = '0;
    reset = 1'b0; start = 1'b0; mode = 1'b0; cin = 1'b0;
    bit_valid = 1'b0; a = 1'b0; b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s", 32'(s), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'(zero_w));
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    // IDLE must ignore bit_valid/a/b.
    bit_valid = 1'b1; a = 1'b1; b = 1'b1;
    @(negedge clk);
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_sv", 32'(s_valid), 32'd0);
    bit_valid = 1'b0;

    // Add cases.
    exp_q.push_back(8'h7F); run_case("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 9);
    exp_q.push_back(8'h80); run_case("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, 9);
    exp_q.push_back(8'h01); run_case("add_ff_01_c1", 8'hFF, 8'h01, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 9);
    exp_q.push_back(8'h25); run_case("add_12_12_c1", 8'h12, 8'h12, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 9);
    // Subtract cases, with cin 0 and 1.
    exp_q.push_back(8'hF0); run_case("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 9);
    exp_q.push_back(8'hF0); run_case("sub_10_20_c1", 8'h10, 8'h20, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 9);
    exp_q.push_back(8'h7F); run_case("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, -1, 0, 1'b0, 1'b1, 1'b1, 9);
    exp_q.push_back(8'h7F); run_case("sub_80_01_c1", 8'h80, 8'h01, 1'b1, 1'b1, -1, 0, 1'b0, 1'b1, 1'b1, 9);
    // Stall of three cycles after three bits.
    exp_q.push_back(8'h7F); run_case("stall", 8'h35, 8'h4A, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, 1'b0, 12);
    // start held high through RUN and DONE.
    exp_q.push_back(8'h46); run_case("poke", 8'h12, 8'h34, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, 1'b0, 9);

    // Mid-word reset after four bits.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bit_valid = 1'b1; a = 1'b1; b = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_s_valid", 32'(s_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'(zero_w));
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    any_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bit_valid = 1'b1; a = 1'b1; b = 1'b0;
      @(negedge clk);
      any_done = any_done | done | busy;
    end
    bit_valid = 1'b0;
    check("mid_rst_no_done", 32'(any_done), 32'd0);
    exp_q.push_back(8'h02); run_case("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
